// File: rtl/sprite_ctrl_pkg.sv
// Shared types, widths and the saturating coordinate-step helper for the
// sprite movement controller.
package sprite_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  // One bit wider than the widest coordinate so pos + step never wraps.
  localparam int C_W = X_W + 1;

  localparam int UP    = 3;
  localparam int DOWN  = 2;
  localparam int LEFT  = 1;
  localparam int RIGHT = 0;

  function automatic logic [C_W-1:0] step_coord(
    input logic [C_W-1:0] pos,
    input logic           dec,
    input logic           inc,
    input logic [C_W-1:0] step,
    input logic [C_W-1:0] max_v
  );
    logic [C_W-1:0] r;
    r = pos;
    if (dec && !inc) begin
      r = (pos < step) ? '0 : pos - step;
    end else if (inc && !dec) begin
      r = (pos + step > max_v) ? max_v : pos + step;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stable-value debouncer for one active-low button;
// output is active-high "pressed".
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic resetn,
  input  logic btn_n,
  output logic pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sample;

  assign sample  = ~sync2_q;
  assign pressed = stable_q;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sample == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sprite_move_ctrl.sv
// Debounced pushbuttons move the sprite once per frame: on the vs falling edge
// the buttons are snapshotted (CALC) and the saturated position is committed.
module sprite_move_ctrl
  import sprite_ctrl_pkg::*;
#(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int STEP            = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           up,
  input  logic           down,
  input  logic           left,
  input  logic           right,
  input  logic           vs,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           moved,
  output logic [3:0]     btn_state,
  output logic [1:0]     state_dbg
);

  localparam logic [C_W-1:0] X_MAX  = C_W'(H_ACTIVE - SPRITE_W);
  localparam logic [C_W-1:0] Y_MAX  = C_W'(V_ACTIVE - SPRITE_H);
  localparam logic [C_W-1:0] STEP_C = C_W'(STEP);
  localparam logic [X_W-1:0] X_RST  = X_W'((H_ACTIVE - SPRITE_W) / 2);
  localparam logic [Y_W-1:0] Y_RST  = Y_W'((V_ACTIVE - SPRITE_H) / 2);

  logic [3:0] raw_n;
  assign raw_n = {up, down, left, right};

  for (genvar i = 0; i < 4; i++) begin : g_db
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock   (clock),
      .resetn  (resetn),
      .btn_n   (raw_n[i]),
      .pressed (btn_state[i])
    );
  end

  state_e         state_q, state_d;
  logic           vs_q;
  logic           tick;
  logic [3:0]     snap_q, snap_d;
  logic [X_W-1:0] pos_x_q, pos_x_d;
  logic [Y_W-1:0] pos_y_q, pos_y_d;
  logic           moved_q, moved_d;
  logic [C_W-1:0] nx, ny;

  assign tick      = vs_q & ~vs;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign moved     = moved_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    moved_d = 1'b0;
    nx = step_coord({1'b0, pos_x_q}, snap_q[LEFT], snap_q[RIGHT], STEP_C, X_MAX);
    ny = step_coord({2'b0, pos_y_q}, snap_q[UP], snap_q[DOWN], STEP_C, Y_MAX);
    case (state_q)
      IDLE: if (tick) state_d = CALC;
      CALC: begin
        snap_d  = btn_state;
        state_d = COMMIT;
      end
      COMMIT: begin
        // Both coordinates land on the same edge so the display never sees a half update.
        pos_x_d = nx[X_W-1:0];
        pos_y_d = ny[Y_W-1:0];
        moved_d = (nx != {1'b0, pos_x_q}) || (ny != {2'b0, pos_y_q});
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      vs_q    <= 1'b1;
      snap_q  <= '0;
      pos_x_q <= X_RST;
      pos_y_q <= Y_RST;
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs;
      snap_q  <= snap_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      moved_q <= moved_d;
    end
  end

endmodule
